// File: rtl/fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch unit.
package fetch_pkg;

  localparam int unsigned INSTR_W         = 32;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned BYTES_PER_INSTR = 4;

  // BYTEk states use k as their low two bits, so the state doubles as the byte lane index.
  typedef enum logic [2:0] {
    FS_BYTE0 = 3'd0,
    FS_BYTE1 = 3'd1,
    FS_BYTE2 = 3'd2,
    FS_BYTE3 = 3'd3,
    FS_HOLD  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_byte_assembler.sv
// Four-lane byte buffer that assembles a little-endian instruction word. The output already
// includes the byte being captured this cycle, so the final lane can be used without a bubble.
module fetch_byte_assembler
  import fetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          lane_sel,
  input  logic                capture,
  input  logic                clear,
  input  logic [BYTE_W-1:0]   byte_in,
  output logic [INSTR_W-1:0]  word
);

  logic [BYTES_PER_INSTR-1:0][BYTE_W-1:0] lanes_q;

  // Lane storage: cleared on reset or discard, otherwise one lane written per capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lanes_q <= '0;
    end else if (clear) begin
      lanes_q <= '0;
    end else if (capture) begin
      lanes_q[lane_sel] <= byte_in;
    end
  end

  // Word view with the incoming byte bypassed into its lane.
  always_comb begin
    word = lanes_q;
    if (capture && !clear) begin
      word[lane_sel*BYTE_W +: BYTE_W] = byte_in;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: walks four byte addresses from pc, assembles the word and presents
// it to decode over valid/ready. A redirect restarts the fetch from a new aligned pc.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic                clk,
  input  logic                reset,
  output logic [31:0]         mem_addr,
  input  logic [BYTE_W-1:0]   mem_byte,
  output logic [INSTR_W-1:0]  instr,
  output logic [31:0]         instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);
  localparam logic [31:0] PC_RESET  = RESET_PC & ADDR_MASK;

  fetch_state_e         state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [31:0]          instr_pc_q, instr_pc_d;
  logic                 valid_q, valid_d;

  logic                 capture;
  logic                 clear;
  logic [1:0]           lane_sel;
  logic [INSTR_W-1:0]   asm_word;

  fetch_byte_assembler u_assembler (
    .clk      (clk),
    .reset    (reset),
    .lane_sel (lane_sel),
    .capture  (capture),
    .clear    (clear),
    .byte_in  (mem_byte),
    .word     (asm_word)
  );

  // State, pc and presented-instruction registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FS_BYTE0;
      pc_q       <= PC_RESET;
      instr_q    <= '0;
      instr_pc_q <= PC_RESET;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic: redirect overrides everything, including a coincident handshake.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    capture    = 1'b0;
    clear      = 1'b0;
    lane_sel   = state_q[1:0];
    mem_addr   = pc_q;

    if (state_q != FS_HOLD) begin
      mem_addr = (pc_q + {30'd0, state_q[1:0]}) & ADDR_MASK;
    end

    if (redirect_valid) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC & ADDR_MASK;
      state_d = FS_BYTE0;
      valid_d = 1'b0;
      clear   = 1'b1;
    end else begin
      unique case (state_q)
        FS_BYTE0: begin
          capture = 1'b1;
          state_d = FS_BYTE1;
        end
        FS_BYTE1: begin
          capture = 1'b1;
          state_d = FS_BYTE2;
        end
        FS_BYTE2: begin
          capture = 1'b1;
          state_d = FS_BYTE3;
        end
        FS_BYTE3: begin
          capture    = 1'b1;
          instr_d    = asm_word;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = FS_HOLD;
        end
        FS_HOLD: begin
          if (instr_ready) begin
            valid_d = 1'b0;
            pc_d    = (pc_q + 32'd4) & ADDR_MASK;
            state_d = FS_BYTE0;
          end
        end
        default: begin
          state_d = FS_BYTE0;
        end
      endcase
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed and randomized checks of inst_fetch_unit against a cycle-level behavioural model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic [7:0]  mem_byte;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [32];
  logic [31:0] prog [8];

  // Behavioural model: fetch progress m_cnt is the number of bytes already collected (4 = holding).
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_valid;
  int          m_cnt;

  // Handshakes observed on the DUT interface, indexed by word address.
  int dut_hs [8];

  inst_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_byte       (mem_byte),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  assign mem_byte = mem[mem_addr[4:0]];

  always @(posedge clk) begin
    if (reset && instr_valid && instr_ready) dut_hs[instr_pc[4:2]] <= dut_hs[instr_pc[4:2]] + 1;
  end

  function automatic logic [31:0] mem_word(logic [31:0] a);
    logic [4:0] i;
    i = a[4:0];
    return {mem[i + 5'd3], mem[i + 5'd2], mem[i + 5'd1], mem[i]};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_cnt = 0; m_valid = 1'b0; m_instr = 32'd0; m_ipc = 32'd0;
  endtask

  task automatic compare_all();
    check("mem_addr", mem_addr, (m_cnt < 4) ? (m_pc + 32'(m_cnt)) % 32 : m_pc);
    check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    check("instr", instr, m_instr);
    check("instr_pc", instr_pc, m_ipc);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else if (redirect_valid) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC & 32'h1F;
      m_cnt = 0;
      m_valid = 1'b0;
    end else if (m_cnt < 3) begin
      m_cnt++;
    end else if (m_cnt == 3) begin
      m_instr = mem_word(m_pc);
      m_ipc = m_pc;
      m_valid = 1'b1;
      m_cnt = 4;
    end else if (instr_ready) begin
      m_valid = 1'b0;
      m_pc = (m_pc + 32'd4) % 32;
      m_cnt = 0;
    end
    #1;
    compare_all();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (instr_valid !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    check("valid_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_instr_pc"}, instr_pc, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
  endtask

  initial begin
    int n;
    int hs_before;
    logic [31:0] held_instr, held_addr;

    prog = '{32'h00940333, 32'h413903b3, 32'h035a02b3, 32'h017b4e33,
             32'h0062c533, 32'h01bd5f33, 32'h40e6d6b3, 32'h00f768b3};
    for (int w = 0; w < 8; w++) begin
      for (int b = 0; b < 4; b++) mem[w*4 + b] = prog[w][b*8 +: 8];
    end
    for (int w = 0; w < 8; w++) dut_hs[w] = 0;

    reset = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    model_reset();
    #2;
    check_reset_outputs("por");
    step();
    step();
    #3 reset = 1'b1;

    // First instruction after reset, then streaming with ready high.
    wait_valid(n);
    check("first_latency", 32'(n), 32'd4);
    check("first_instr", instr, 32'h00940333);
    check("first_pc", instr_pc, 32'd0);
    step();
    wait_valid(n);
    check("second_interval", 32'(n + 1), 32'd5);
    check("second_instr", instr, 32'h413903b3);
    check("second_pc", instr_pc, 32'd4);

    // Backpressure on pc 8.
    step();
    instr_ready = 1'b0;
    wait_valid(n);
    check("bp_instr", instr, 32'h035a02b3);
    held_instr = instr;
    held_addr = mem_addr;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_instr", instr, held_instr);
      check("bp_hold_pc", instr_pc, 32'd8);
      check("bp_hold_addr", mem_addr, held_addr);
    end
    hs_before = dut_hs[2];
    instr_ready = 1'b1;
    step();
    check("bp_handshake", 32'(dut_hs[2] - hs_before), 32'd1);
    check("bp_next_addr", mem_addr, 32'd12);
    wait_valid(n);

    // Wrap-around from pc 28 to pc 0.
    redirect_valid = 1'b1; redirect_pc = 32'd28;
    step();
    redirect_valid = 1'b0;
    wait_valid(n);
    check("wrap_instr", instr, 32'h00f768b3);
    check("wrap_pc", instr_pc, 32'd28);
    step();
    for (int k = 0; k < 4; k++) begin
      check("wrap_addr", mem_addr, 32'(k));
      if (k < 3) step();
    end
    wait_valid(n);
    check("wrap_next_instr", instr, 32'h00940333);
    check("wrap_next_pc", instr_pc, 32'd0);

    // Mid-fetch redirect during BYTE2 of pc 4.
    step();
    step();
    step();
    check("mid_byte2_addr", mem_addr, 32'd6);
    hs_before = dut_hs[1];
    redirect_valid = 1'b1; redirect_pc = 32'd8;
    step();
    redirect_valid = 1'b0;
    wait_valid(n);
    check("mid_instr", instr, 32'h035a02b3);
    check("mid_pc", instr_pc, 32'd8);
    check("mid_no_pc4", 32'(dut_hs[1] - hs_before), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'd13;
    step();
    redirect_valid = 1'b0;
    wait_valid(n);
    check("unaligned_instr", instr, 32'h017b4e33);
    check("unaligned_pc", instr_pc, 32'd12);

    // Redirect coinciding with a handshake of pc 0.
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    step();
    redirect_valid = 1'b0;
    wait_valid(n);
    hs_before = dut_hs[0];
    redirect_valid = 1'b1; redirect_pc = 32'd20;
    step();
    redirect_valid = 1'b0;
    check("coinc_handshake", 32'(dut_hs[0] - hs_before), 32'd1);
    check("coinc_addr", mem_addr, 32'd20);
    wait_valid(n);
    check("coinc_instr", instr, 32'h01bd5f33);
    check("coinc_pc", instr_pc, 32'd20);

    // Asynchronous reset pulse during BYTE1 of pc 16.
    redirect_valid = 1'b1; redirect_pc = 32'd16;
    step();
    redirect_valid = 1'b0;
    step();
    check("arst_byte1_addr", mem_addr, 32'd17);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("arst");
    #2 reset = 1'b1;
    wait_valid(n);
    check("arst_latency", 32'(n), 32'd4);
    check("arst_instr", instr, 32'h00940333);
    check("arst_pc", instr_pc, 32'd0);

    // Randomized memory contents, ready and redirects against the model.
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    redirect_valid = 1'b1; redirect_pc = $urandom;
    step();
    for (int i = 0; i < 400; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
